adder_pipe: RTL

ADDER_PIPE -- requirements
Module: adder_pipe

---
 rtl/adder_pipe_if.sv | 37 +++
 rtl/adder_pipe.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/adder_pipe_if.sv
// Handshake and data bundle for adder_pipe.
// The optional sub signal exists only when ADDER_PIPE_SUB_EN is defined.
interface adder_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef ADDER_PIPE_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Producer/consumer side (testbench or surrounding logic)
    modport master (
`ifdef ADDER_PIPE_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // Adder side
    modport slave (
`ifdef ADDER_PIPE_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined carry-chain adder with valid/ready handshake.
// The WIDTH-bit add is split into STAGES segments of WIDTH/STAGES bits;
// segment k is added in stage k using the carry registered by stage k-1.
// Unconsumed operand bits travel forward and completed low sums are skewed
// so a whole result leaves the last stage at once.
// Optional feature macro: ADDER_PIPE_SUB_EN adds a per-beat sub input
// (a - b, cin ignored). The connected interface WIDTH must equal WIDTH.
module adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic         clk,
    input logic         rst,
    adder_pipe_if.slave bus
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Effective operands: subtraction is a + ~b + 1
    always_comb begin
`ifdef ADDER_PIPE_SUB_EN
        b_eff   = bus.sub ? ~bus.b : bus.b;
        cin_eff = bus.sub | bus.cin;
`else
        b_eff   = bus.b;
        cin_eff = bus.cin;
`endif
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // IW: operand bits still to be added on entry to this stage
        // SW: result bits completed once this stage has added its segment
        localparam int IW = WIDTH - k * SEG;
        localparam int SW = (k + 1) * SEG;

        logic [IW-1:0] in_a;
        logic [IW-1:0] in_b;
        logic          in_c;
        logic          in_v;
        logic [SEG:0]  seg_sum;
        logic [SW-1:0] s_next;
        logic [SW-1:0] s_q;
        logic          v_q;
        logic          c_q;

        if (k == 0) begin : g_src
            // First stage takes operands straight from the port
            always_comb begin
                in_a = bus.a;
                in_b = b_eff;
                in_c = cin_eff;
                in_v = bus.in_valid;
            end

            // First segment result is the whole partial sum
            always_comb begin
                s_next = seg_sum[SEG-1:0];
            end
        end else begin : g_src
            // Later stages consume what the previous stage carried forward
            always_comb begin
                in_a = g_stage[k-1].g_ops.a_q;
                in_b = g_stage[k-1].g_ops.b_q;
                in_c = g_stage[k-1].c_q;
                in_v = g_stage[k-1].v_q;
            end

            // New segment goes on top of the skewed lower sum bits
            always_comb begin
                s_next = {seg_sum[SEG-1:0], g_stage[k-1].s_q};
            end
        end

        // Segment add: low SEG operand bits plus the incoming carry
        always_comb begin
            seg_sum = {1'b0, in_a[SEG-1:0]} + {1'b0, in_b[SEG-1:0]}
                    + {{SEG{1'b0}}, in_c};
        end

        // Stage register; data only loads with a valid beat so bubbles leave it untouched
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= in_v;
                if (in_v) begin
                    c_q <= seg_sum[SEG];
                    s_q <= s_next;
                end
            end
        end

        if (k < LAST) begin : g_ops
            logic [IW-SEG-1:0] a_q;
            logic [IW-SEG-1:0] b_q;

            // Carry the not-yet-added operand bits to the next stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance && in_v) begin
                    a_q <= in_a[IW-1:SEG];
                    b_q <= in_b[IW-1:SEG];
                end
            end
        end else begin : g_last
            logic ovf_q;

            // Carry into the MSB is recovered as a^b^sum at that bit
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance && in_v) begin
                    ovf_q <= seg_sum[SEG] ^ (in_a[SEG-1] ^ in_b[SEG-1] ^ seg_sum[SEG-1]);
                end
            end
        end
    end

    // Global stall: whole pipe moves only if the output slot is free or being taken
    always_comb begin
        advance = !g_stage[LAST].v_q || bus.out_ready;
    end

    // Output port mapping from the last stage registers
    always_comb begin
        bus.in_ready  = advance;
        bus.out_valid = g_stage[LAST].v_q;
        bus.sum       = g_stage[LAST].s_q;
        bus.cout      = g_stage[LAST].c_q;
        bus.ovf       = g_stage[LAST].g_last.ovf_q;
    end
endmodule
